// File: rtl/multi_blink_bank_if.sv
// multi_blink_bank_if: switch/sync inputs and LED/status outputs of the blinker bank
interface multi_blink_bank_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   i_Switch;
    logic                i_Sync;
    logic [NUM_CH-1:0]   o_LED;
    logic [NUM_CH-1:0]   o_Active;
    logic [NUM_CH*3-1:0] o_Rate;
    modport master (output i_Switch, i_Sync, input o_LED, o_Active, o_Rate);
    modport slave  (input i_Switch, i_Sync, output o_LED, o_Active, o_Rate);
endinterface

// File: rtl/multi_blink_bank.sv
// multi_blink_bank: per-channel debounced button stepping an LED through OFF and NUM_RATES blink rates
module multi_blink_bank #(
    parameter int NUM_CH       = 4,
    parameter int NUM_RATES    = 4,
    parameter int BASE_DELAY   = 2000000,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int CNT_W        = 24,
    parameter int DB_W         = 18
) (
    input logic               i_Clk,
    input logic               i_Rst_L,
    multi_blink_bank_if.slave bus
);
    if ((64'(BASE_DELAY) << (NUM_RATES - 1)) > (64'd1 << CNT_W)) begin : g_cnt_chk
        $error("CNT_W too narrow for the slowest blink rate");
    end
    if (64'(DEBOUNCE_CYC) > (64'd1 << DB_W)) begin : g_db_chk
        $error("DB_W too narrow for DEBOUNCE_CYC");
    end
    logic [NUM_CH-1:0] sync1_q, sync2_q, stable_q, stable_d, stable_dly_q;
    logic [NUM_CH-1:0] rel_q, rel_d, active_q, active_d, led_q, led_d;
    logic [DB_W-1:0]   db_cnt_q  [NUM_CH];
    logic [DB_W-1:0]   db_cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  blk_cnt_q [NUM_CH];
    logic [CNT_W-1:0]  blk_cnt_d [NUM_CH];
    logic [2:0]        rate_q    [NUM_CH];
    logic [2:0]        rate_d    [NUM_CH];
    // terminal count of rate r: (BASE_DELAY << r) - 1, computed one bit wider to avoid overflow
    function automatic logic [CNT_W-1:0] last_cnt(input logic [2:0] r);
        logic [CNT_W:0] h;
        h = (CNT_W+1)'(BASE_DELAY) << r;
        return CNT_W'(h - (CNT_W+1)'(1));
    endfunction
    always_comb begin
        stable_d  = stable_q;
        rel_d     = '0;
        active_d  = active_q;
        led_d     = led_q;
        db_cnt_d  = db_cnt_q;
        blk_cnt_d = blk_cnt_q;
        rate_d    = rate_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sync2_q[c] == stable_q[c]) db_cnt_d[c] = '0;
            else if (db_cnt_q[c] == DB_W'(DEBOUNCE_CYC - 1)) begin
                db_cnt_d[c] = '0;
                stable_d[c] = sync2_q[c];
            end else db_cnt_d[c] = db_cnt_q[c] + DB_W'(1);
            rel_d[c] = stable_dly_q[c] & ~stable_q[c];
            // a release outranks sync: the new state always restarts its own phase
            if (rel_q[c]) begin
                active_d[c]  = !active_q[c] || rate_q[c] != 3'(NUM_RATES - 1);
                rate_d[c]    = (active_q[c] && active_d[c]) ? rate_q[c] + 3'd1 : 3'd0;
                blk_cnt_d[c] = '0;
                led_d[c]     = active_d[c];
            end else if (!active_q[c]) begin
                blk_cnt_d[c] = '0;
                led_d[c]     = 1'b0;
            end else if (bus.i_Sync) begin
                blk_cnt_d[c] = '0;
                led_d[c]     = 1'b1;
            end else if (blk_cnt_q[c] == last_cnt(rate_q[c])) begin
                blk_cnt_d[c] = '0;
                led_d[c]     = ~led_q[c];
            end else blk_cnt_d[c] = blk_cnt_q[c] + CNT_W'(1);
        end
    end
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            rel_q        <= '0;
            active_q     <= '0;
            led_q        <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                db_cnt_q[c]  <= '0;
                blk_cnt_q[c] <= '0;
                rate_q[c]    <= '0;
            end
        end else begin
            sync1_q      <= bus.i_Switch;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            rel_q        <= rel_d;
            active_q     <= active_d;
            led_q        <= led_d;
            db_cnt_q     <= db_cnt_d;
            blk_cnt_q    <= blk_cnt_d;
            rate_q       <= rate_d;
        end
    end
    assign bus.o_LED    = led_q;
    assign bus.o_Active = active_q;
    for (genvar g = 0; g < NUM_CH; g++) begin : g_rate
        assign bus.o_Rate[3*g +: 3] = rate_q[g];
    end
endmodule

// File: tb/tb_multi_blink_bank.sv
// tb_multi_blink_bank: directed test-plan sequence plus random buttons/sync against a phase-based model
module tb_multi_blink_bank;
    localparam int NC = 2;
    localparam int NR = 2;
    localparam int BD = 3;
    localparam int DC = 4;
    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NC-1:0] sw    = '1;
    logic          sync  = 1'b0;
    int            pass_cnt = 0;
    int            total_cnt = 0;
    multi_blink_bank_if #(.NUM_CH(NC)) bus ();
    assign bus.i_Switch = sw;
    assign bus.i_Sync   = sync;
    multi_blink_bank #(
        .NUM_CH(NC), .NUM_RATES(NR), .BASE_DELAY(BD), .DEBOUNCE_CYC(DC), .CNT_W(4), .DB_W(3)
    ) dut (
        .i_Clk(clk),
        .i_Rst_L(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask
    // model: pin history window for debounce, edge number of each stable fall,
    // and a phase count since the last restart from which the LED is derived by division
    int hist [NC];
    bit m_stable [NC];
    bit m_active [NC];
    int m_rate [NC];
    int m_phase [NC];
    int fall_edge [NC];
    int edge_n;
    always @(posedge clk) begin
        logic [31:0] e_led, e_act, e_rate;
        int win;
        if (!rst_n) begin
            edge_n = 0;
            for (int c = 0; c < NC; c++) begin
                hist[c] = 0; m_stable[c] = 0; m_active[c] = 0;
                m_rate[c] = 0; m_phase[c] = 0; fall_edge[c] = -10;
            end
        end else begin
            edge_n++;
            for (int c = 0; c < NC; c++) begin
                hist[c] = (hist[c] << 1) | int'(sw[c]);
                if (edge_n == fall_edge[c] + 2) begin
                    if (!m_active[c]) begin m_active[c] = 1; m_rate[c] = 0; end
                    else if (m_rate[c] == NR - 1) begin m_active[c] = 0; m_rate[c] = 0; end
                    else m_rate[c]++;
                    m_phase[c] = 0;
                end else if (m_active[c]) m_phase[c] = sync ? 0 : m_phase[c] + 1;
                win = (hist[c] >> 2) & ((1 << DC) - 1);
                if (win == (m_stable[c] ? 0 : (1 << DC) - 1)) begin
                    m_stable[c] = !m_stable[c];
                    if (!m_stable[c]) fall_edge[c] = edge_n;
                end
            end
        end
        #1;
        e_led = 0; e_act = 0; e_rate = 0;
        for (int c = 0; c < NC; c++) begin
            if (m_active[c]) begin
                e_act[c] = 1'b1;
                e_led[c] = ((m_phase[c] / (BD << m_rate[c])) % 2) == 0;
                e_rate  |= 32'(m_rate[c]) << (3 * c);
            end
        end
        check("model_led", 32'(bus.o_LED), e_led);
        check("model_active", 32'(bus.o_Active), e_act);
        check("model_rate", 32'(bus.o_Rate), e_rate);
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic press_release(input int c);
        sw[c] = 1'b1;
        tick(8);
        sw[c] = 1'b0;
        tick(8);
    endtask
    initial begin
        tick(3);
        check("reset_led", 32'(bus.o_LED), 0);
        check("reset_active", 32'(bus.o_Active), 0);
        check("reset_rate", 32'(bus.o_Rate), 0);
        rst_n = 1'b1;
        tick(10);
        check("held_active", 32'(bus.o_Active), 0);
        check("held_led", 32'(bus.o_LED), 0);
        sw = 2'b00;
        tick(7);
        check("rel_not_yet", 32'(bus.o_Active), 0);
        tick(1);
        check("rel_active", 32'(bus.o_Active), 32'b11);
        check("rel_rate", 32'(bus.o_Rate), 0);
        check("rel_led", 32'(bus.o_LED), 32'b11);
        tick(2);
        check("r0_led_hi", 32'(bus.o_LED), 32'b11);
        tick(1);
        check("r0_led_lo", 32'(bus.o_LED), 32'b00);
        press_release(0);
        check("r1_rate", 32'(bus.o_Rate), 32'b000_001);
        check("r1_led_hi", 32'(bus.o_LED[0]), 1);
        tick(5);
        check("r1_led_still", 32'(bus.o_LED[0]), 1);
        tick(1);
        check("r1_led_lo", 32'(bus.o_LED[0]), 0);
        press_release(0);
        check("off_active", 32'(bus.o_Active), 32'b10);
        check("off_led", 32'(bus.o_LED[0]), 0);
        sw[1] = 1'b1; tick(3);
        sw[1] = 1'b0; tick(1);
        sw[1] = 1'b1; tick(3);
        sw[1] = 1'b0; tick(20);
        check("bounce_active", 32'(bus.o_Active), 32'b10);
        check("bounce_rate", 32'(bus.o_Rate), 0);
        press_release(0);
        press_release(1);
        check("pre_sync_rate", 32'(bus.o_Rate), 32'b001_000);
        tick($urandom_range(1, 10));
        sync = 1'b1; tick(1); sync = 1'b0;
        check("sync_led", 32'(bus.o_LED), 32'b11);
        tick(2);
        check("sync_led_s2", 32'(bus.o_LED), 32'b11);
        tick(1);
        check("sync_led_s3", 32'(bus.o_LED), 32'b10);
        tick(2);
        check("sync_led_s5", 32'(bus.o_LED), 32'b10);
        tick(1);
        check("sync_led_s6", 32'(bus.o_LED), 32'b01);
        tick($urandom_range(1, 5));
        sw[0] = 1'b1; tick(8);
        sw[0] = 1'b0; tick(7);
        sync = 1'b1; tick(1); sync = 1'b0;
        check("coinc_rate", 32'(bus.o_Rate), 32'b001_001);
        check("coinc_led", 32'(bus.o_LED), 32'b11);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        check("async_led", 32'(bus.o_LED), 0);
        check("async_active", 32'(bus.o_Active), 0);
        check("async_rate", 32'(bus.o_Rate), 0);
        tick(3);
        sw = NC'($urandom_range(0, 3));
        rst_n = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NC; c++) if ($urandom_range(0, 5) == 0) sw[c] = ~sw[c];
            sync = ($urandom_range(0, 15) == 0);
            tick(1);
        end
        sync = 1'b0;
        tick(2);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
